rank_filter: RTL and testbench

- Parametrised streaming rank-order filter, the successor to the fixed 9-sample median block.
- Collects a window of N samples of width W and sorts them in place with an odd-even transposition network (one phase per cycle).
- Outputs the sample at a run-time-selectable rank: 0 = min, (N-1)/2 = median, N-1 = max.
- Sits in the image-filter datapath between the pixel source and the downstream writer, with a DSI/DSO strobe interface plus a ready flag.

---
 rtl/rank_filter_pkg.sv | 10 +
 rtl/rank_filter_cmp_swap.sv | 21 ++
 rtl/rank_filter.sv | 130 +++++++++++++
 tb/tb_rank_filter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// Shared types and helpers for the streaming rank-order filter.
package rank_filter_pkg;

  typedef enum logic [1:0] {S_COLLECT, S_SORT, S_OUT} state_t;

  function automatic int median_rank(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/rank_filter_cmp_swap.sv
// Combinational compare-exchange cell: ascending, unsigned; equal inputs never swap.
module cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         en,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  always_comb begin
    lo = a;
    hi = b;
    if (en && (a > b)) begin
      lo = b;
      hi = a;
    end
  end

endmodule

// File: rtl/rank_filter.sv
// Streaming rank-order filter: collect N samples, sort with an odd-even
// transposition network (one phase per cycle), emit the sample at the latched rank.
module rank_filter
  import rank_filter_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 9,
  localparam int RW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [W-1:0]  DI,
  input  logic          DSI,
  input  logic [RW-1:0] RANK,
  output logic          RDY,
  output logic [W-1:0]  DO,
  output logic          DSO
);

  if (((N % 2) == 0) || (N < 3)) begin : g_param_check
    $error("rank_filter: N must be odd and >= 3");
  end

  localparam logic [RW-1:0] CNT_LAST = RW'(N - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_cnt;
  logic [RW-1:0]   r_rank;
  logic [W-1:0]    r_buf [N];
  logic [W-1:0]    r_do;
  logic            r_dso;

  logic [N-2:0]    w_en;
  logic [W-1:0]    w_lo [N-1];
  logic [W-1:0]    w_hi [N-1];
  logic [W-1:0]    w_sorted [N];
  logic [RW-1:0]   w_rank_clamped;
  logic            w_cnt_last;

  assign RDY            = (r_state == S_COLLECT);
  assign DO             = r_do;
  assign DSO            = r_dso;
  assign w_cnt_last     = (r_cnt == CNT_LAST);
  assign w_rank_clamped = (RANK > CNT_LAST) ? CNT_LAST : RANK;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (DSI && w_cnt_last) w_state_nxt = S_SORT;
      S_SORT:    if (w_cnt_last)        w_state_nxt = S_OUT;
      S_OUT:                            w_state_nxt = S_COLLECT;
      default:                          w_state_nxt = S_COLLECT;
    endcase
  end

  // Even phases enable cells 0,2,4..; odd phases enable 1,3,5..
  always_comb begin
    w_en = '0;
    for (int unsigned k = 0; k < N - 1; k++) begin
      w_en[k] = (r_state == S_SORT) && (r_cnt[0] == k[0]);
    end
  end

  for (genvar k = 0; k < N - 1; k++) begin : g_cs
    cmp_swap #(.W(W)) u_cs (
      .a  (r_buf[k]),
      .b  (r_buf[k+1]),
      .en (w_en[k]),
      .lo (w_lo[k]),
      .hi (w_hi[k])
    );
  end

  // Enabled cells in one phase never share an element, so only they write back.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_sorted[i] = r_buf[i];
    end
    for (int unsigned k = 0; k < N - 1; k++) begin
      if (w_en[k]) begin
        w_sorted[k]   = w_lo[k];
        w_sorted[k+1] = w_hi[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt  <= '0;
      r_rank <= '0;
      r_do   <= '0;
      r_dso  <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_dso <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (DSI) begin
            r_buf[0] <= DI;
            for (int unsigned i = 1; i < N; i++) begin
              r_buf[i] <= r_buf[i-1];
            end
            if (r_cnt == '0) r_rank <= w_rank_clamped;
            r_cnt <= w_cnt_last ? '0 : r_cnt + RW'(1);
          end
        end
        S_SORT: begin
          for (int unsigned i = 0; i < N; i++) begin
            r_buf[i] <= w_sorted[i];
          end
          r_cnt <= w_cnt_last ? '0 : r_cnt + RW'(1);
        end
        S_OUT: begin
          r_do  <= r_buf[r_rank];
          r_dso <= 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rank_filter.sv
// Directed self-checking bench for rank_filter (W=8, N=9).
module tb_rank_filter;
  import rank_filter_pkg::*;

  localparam int W  = 8;
  localparam int N  = 9;
  localparam int RW = $clog2(N);

  typedef logic [W-1:0] win_t [N];

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [W-1:0]  DI = '0;
  logic          DSI = 1'b0;
  logic [RW-1:0] RANK = '0;
  logic          RDY;
  logic [W-1:0]  DO;
  logic          DSO;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  rank_filter #(.W(W), .N(N)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .DI   (DI),
    .DSI  (DSI),
    .RANK (RANK),
    .RDY  (RDY),
    .DO   (DO),
    .DSO  (DSO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // r0 goes with sample 0; rr is driven on all later samples.
  task automatic push_window(input win_t s, input logic [RW-1:0] r0,
                             input logic [RW-1:0] rr, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && (i == 2 || i == 5 || i == 6)) begin
        DSI = 1'b0;
        DI  = 8'hFF;
        step();
        if (i == 5) step();
      end
      DI   = s[i];
      DSI  = 1'b1;
      RANK = (i == 0) ? r0 : rr;
      step();
    end
    DSI = 1'b0;
  endtask

  // Waits for DSO from the point just after the last-sample edge; junk drives
  // DSI=1/DI=FF while waiting to prove the block drops it.
  task automatic wait_result(input bit junk, output int n, output int rdy_low);
    n = 0;
    rdy_low = 0;
    while (!DSO && n < 40) begin
      if (!RDY) rdy_low++;
      DSI = junk;
      DI  = 8'hFF;
      step();
      n++;
    end
    DSI = 1'b0;
  endtask

  win_t w_mix, w_split, w_tie;
  int n, low, c1, gap;

  initial begin
    w_mix   = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    w_split = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    w_tie   = '{default: 8'hAA};

    #12;
    check("reset_do", DO, 0);
    check("reset_dso", DSO, 0);
    check("reset_rdy", RDY, 1);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // Case 1: median, latency, RDY-low span, one-cycle DSO, DO hold
    push_window(w_mix, RW'(median_rank(N)), RW'(median_rank(N)), 1'b0);
    check("c1_rdy_after_last", RDY, 0);
    wait_result(1'b0, n, low);
    check("c1_latency", n, N + 1);
    check("c1_rdy_low_cycles", low, N + 1);
    check("c1_do", DO, 5);
    check("c1_rdy_in_dso", RDY, 1);
    step();
    check("c1_dso_one_cycle", DSO, 0);
    check("c1_do_held", DO, 5);

    // Case 2: min, max, clamped rank, mid-window rank change ignored
    push_window(w_mix, 4'd0, 4'd8, 1'b0);
    wait_result(1'b0, n, low);
    check("c2_min", DO, 1);
    push_window(w_mix, 4'd8, 4'd0, 1'b0);
    wait_result(1'b0, n, low);
    check("c2_max", DO, 9);
    push_window(w_mix, 4'd15, 4'd2, 1'b0);
    wait_result(1'b0, n, low);
    check("c2_clamp", DO, 9);

    // Case 3: DSI gaps plus junk presented during SORT/OUT
    push_window(w_mix, 4'd4, 4'd4, 1'b1);
    wait_result(1'b1, n, low);
    check("c3_latency", n, N + 1);
    check("c3_do", DO, 5);

    // Case 4: split window and all-equal window; also proves junk was not counted
    push_window(w_split, 4'd4, 4'd4, 1'b0);
    wait_result(1'b0, n, low);
    check("c4_latency", n, N + 1);
    check("c4_split", DO, 255);
    push_window(w_tie, 4'd4, 4'd4, 1'b0);
    wait_result(1'b0, n, low);
    check("c4_ties", DO, 8'hAA);

    // Case 5: reset during SORT
    push_window(w_split, 4'd0, 4'd0, 1'b0);
    step();
    step();
    step();
    check("c5_in_sort", RDY, 0);
    nRST = 1'b0;
    #2;
    check("c5_rst_do", DO, 0);
    check("c5_rst_dso", DSO, 0);
    check("c5_rst_rdy", RDY, 1);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    check("c5_no_dso", DSO, 0);
    push_window(w_mix, 4'd4, 4'd4, 1'b0);
    wait_result(1'b0, n, low);
    check("c5_latency", n, N + 1);
    check("c5_do", DO, 5);

    // Case 6: back-to-back windows, window 2 starts in the DSO cycle
    push_window(w_mix, 4'd4, 4'd4, 1'b0);
    wait_result(1'b0, n, low);
    c1 = cyc;
    check("c6_do1", DO, 5);
    push_window(w_split, 4'd5, 4'd5, 1'b0);
    wait_result(1'b0, n, low);
    gap = cyc - c1;
    check("c6_do2", DO, 255);
    check("c6_dso2", DSO, 1);
    check("c6_gap", gap, 2 * N + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
